// File: rtl/alu_seq.sv
// alu_seq - handshaked, multi-cycle ALU with an architectural NZCV flag register.
//
// One operation is accepted per transaction on the in_valid/in_ready channel.
// Its result and C/V/N/Z flags are returned on the out_valid/out_ready channel.
// Single-cycle operations complete on the accept edge. MUL (and DIVU when the
// divider is built) iterate one bit per cycle in BUSY for WIDTH cycles.
//
// Parameters:
//   WIDTH  operand/result width (>= 4, power of two)
//   SHW    shift-amount width, derived as $clog2(WIDTH)
//
// Ports:
//   clk, rst_n             rising-edge clock, synchronous active-low reset
//   in_valid / in_ready    operation handshake
//   op, operand1, operand2 opcode and operands (operand2 also gives the shift amount)
//   set_flags              load the flag register when this operation completes
//   out_valid / out_ready  result handshake
//   result, carry, overflow, negative, zero, illegal   per-operation outputs
//   flag_c, flag_v, flag_n, flag_z                     architectural flag register
//
// Build option:
//   ALU_SEQ_DIVIDER_EN  when defined, opcode 1100 (DIVU) is a restoring unsigned
//                       divider. When undefined, 1100 is illegal and no divider
//                       logic exists.

module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic             set_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             negative,
    output logic             zero,
    output logic             illegal,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_n,
    output logic             flag_z
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NOT  = 4'b0101;
    localparam logic [3:0] OP_PASS = 4'b0110;
    localparam logic [3:0] OP_ADC  = 4'b0111;
    localparam logic [3:0] OP_SHL  = 4'b1000;
    localparam logic [3:0] OP_SHR  = 4'b1001;
    localparam logic [3:0] OP_ASR  = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1011;
`ifdef ALU_SEQ_DIVIDER_EN
    localparam logic [3:0] OP_DIVU = 4'b1100;
`endif

    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    // Two's-complement overflow: operands agree in sign, sum disagrees.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    logic [1:0]       state_r;
    logic [SHW-1:0]   cnt_r;
    logic             set_flags_r;
    logic [WIDTH-1:0] acc_hi_r;
    logic [WIDTH-1:0] acc_lo_r;
    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] result_r;
    logic             carry_r;
    logic             overflow_r;
    logic             negative_r;
    logic             zero_r;
    logic             illegal_r;
    logic             flag_c_r;
    logic             flag_v_r;
    logic             flag_n_r;
    logic             flag_z_r;
`ifdef ALU_SEQ_DIVIDER_EN
    logic             is_div_r;
    logic             div_s;
    logic [WIDTH:0]   rem_sh_s;
    logic [WIDTH:0]   diff_s;
`endif

    logic [WIDTH-1:0] add_b_s;
    logic             add_cin_s;
    logic [WIDTH:0]   sum_s;
    logic [SHW-1:0]   amt_s;
    logic [WIDTH:0]   shl_s;
    logic [WIDTH:0]   shr_s;
    logic [WIDTH:0]   asr_s;
    logic [WIDTH-1:0] res_s;
    logic             c_s;
    logic             v_s;
    logic             n_s;
    logic             z_s;
    logic             ill_s;
    logic             multi_s;
    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH-1:0] hi_nxt_s;
    logic [WIDTH-1:0] lo_nxt_s;

    // Adder operand selection: SUB inverts operand2 with carry-in 1, ADC takes the stored carry.
    always_comb begin
        add_b_s   = operand2;
        add_cin_s = 1'b0;
        case (op)
            OP_SUB: begin
                add_b_s   = ~operand2;
                add_cin_s = 1'b1;
            end
            OP_ADC: begin
                add_b_s   = operand2;
                add_cin_s = flag_c_r;
            end
            default: begin
                add_b_s   = operand2;
                add_cin_s = 1'b0;
            end
        endcase
        sum_s = {1'b0, operand1} + {1'b0, add_b_s} + {{WIDTH{1'b0}}, add_cin_s};
    end

    // Shifters carry one extra bit so the last bit shifted out falls into a fixed position
    // and is naturally 0 for a zero shift amount.
    always_comb begin
        amt_s = operand2[SHW-1:0];
        shl_s = {1'b0, operand1} << amt_s;
        shr_s = {operand1, 1'b0} >> amt_s;
        asr_s = $unsigned($signed({operand1, 1'b0}) >>> amt_s);
    end

    // Single-cycle result/flag decode, plus selection of the iterative path.
    always_comb begin
        res_s   = {WIDTH{1'b0}};
        c_s     = 1'b0;
        v_s     = 1'b0;
        n_s     = 1'b0;
        ill_s   = 1'b0;
        multi_s = 1'b0;
`ifdef ALU_SEQ_DIVIDER_EN
        div_s   = 1'b0;
`endif
        case (op)
            OP_ADD, OP_SUB, OP_ADC: begin
                res_s = sum_s[WIDTH-1:0];
                c_s   = sum_s[WIDTH];
                v_s   = add_ovf(operand1[WIDTH-1], add_b_s[WIDTH-1], sum_s[WIDTH-1]);
                n_s   = sum_s[WIDTH-1];
            end
            OP_AND:  res_s = operand1 & operand2;
            OP_OR:   res_s = operand1 | operand2;
            OP_XOR:  res_s = operand1 ^ operand2;
            OP_NOT:  res_s = ~operand2;
            OP_PASS: res_s = operand2;
            OP_SHL: begin
                res_s = shl_s[WIDTH-1:0];
                c_s   = shl_s[WIDTH];
                n_s   = shl_s[WIDTH-1];
            end
            OP_SHR: begin
                res_s = shr_s[WIDTH:1];
                c_s   = shr_s[0];
                n_s   = shr_s[WIDTH];
            end
            OP_ASR: begin
                res_s = asr_s[WIDTH:1];
                c_s   = asr_s[0];
                n_s   = asr_s[WIDTH];
            end
            OP_MUL: multi_s = 1'b1;
`ifdef ALU_SEQ_DIVIDER_EN
            OP_DIVU: begin
                // Divide by zero short-circuits to all ones in a single cycle.
                if (operand2 == {WIDTH{1'b0}}) begin
                    res_s = {WIDTH{1'b1}};
                    v_s   = 1'b1;
                    n_s   = 1'b1;
                end else begin
                    multi_s = 1'b1;
                    div_s   = 1'b1;
                end
            end
`endif
            default: ill_s = 1'b1;
        endcase
        z_s = ~ill_s & ~(|res_s);
    end

    // One iteration step: shift-add multiply on {acc_hi, acc_lo}, or restoring divide
    // with acc_hi as remainder and acc_lo shifting dividend out / quotient in.
    always_comb begin
        mul_sum_s = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
`ifdef ALU_SEQ_DIVIDER_EN
        rem_sh_s = {acc_hi_r, acc_lo_r[WIDTH-1]};
        diff_s   = rem_sh_s - {1'b0, mcand_r};
        if (is_div_r) begin
            if (!diff_s[WIDTH]) begin
                hi_nxt_s = diff_s[WIDTH-1:0];
                lo_nxt_s = {acc_lo_r[WIDTH-2:0], 1'b1};
            end else begin
                hi_nxt_s = rem_sh_s[WIDTH-1:0];
                lo_nxt_s = {acc_lo_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            {hi_nxt_s, lo_nxt_s} = {mul_sum_s, acc_lo_r[WIDTH-1:1]};
        end
`else
        {hi_nxt_s, lo_nxt_s} = {mul_sum_s, acc_lo_r[WIDTH-1:1]};
`endif
    end

    // Control FSM, iteration datapath, output registers and flag register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            cnt_r       <= {SHW{1'b0}};
            set_flags_r <= 1'b0;
            acc_hi_r    <= {WIDTH{1'b0}};
            acc_lo_r    <= {WIDTH{1'b0}};
            mcand_r     <= {WIDTH{1'b0}};
            result_r    <= {WIDTH{1'b0}};
            carry_r     <= 1'b0;
            overflow_r  <= 1'b0;
            negative_r  <= 1'b0;
            zero_r      <= 1'b0;
            illegal_r   <= 1'b0;
            flag_c_r    <= 1'b0;
            flag_v_r    <= 1'b0;
            flag_n_r    <= 1'b0;
            flag_z_r    <= 1'b0;
`ifdef ALU_SEQ_DIVIDER_EN
            is_div_r    <= 1'b0;
`endif
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (in_valid) begin
                        set_flags_r <= set_flags;
                        if (multi_s) begin
                            state_r  <= S_BUSY;
                            cnt_r    <= {SHW{1'b0}};
                            mcand_r  <= operand2;
                            acc_hi_r <= {WIDTH{1'b0}};
                            acc_lo_r <= operand1;
`ifdef ALU_SEQ_DIVIDER_EN
                            is_div_r <= div_s;
`endif
                        end else begin
                            state_r    <= S_DONE;
                            result_r   <= res_s;
                            carry_r    <= c_s;
                            overflow_r <= v_s;
                            negative_r <= n_s;
                            zero_r     <= z_s;
                            illegal_r  <= ill_s;
                            if (set_flags && !ill_s) begin
                                flag_c_r <= c_s;
                                flag_v_r <= v_s;
                                flag_n_r <= n_s;
                                flag_z_r <= z_s;
                            end
                        end
                    end
                end
                S_BUSY: begin
                    acc_hi_r <= hi_nxt_s;
                    acc_lo_r <= lo_nxt_s;
                    cnt_r    <= cnt_r + SHW'(1'b1);
                    if (cnt_r == CNT_LAST) begin
                        // Final step: low half is product/quotient, high half is
                        // product overflow/remainder; either nonzero sets carry.
                        state_r    <= S_DONE;
                        result_r   <= lo_nxt_s;
                        carry_r    <= |hi_nxt_s;
                        overflow_r <= 1'b0;
                        negative_r <= lo_nxt_s[WIDTH-1];
                        zero_r     <= ~(|lo_nxt_s);
                        illegal_r  <= 1'b0;
                        if (set_flags_r) begin
                            flag_c_r <= |hi_nxt_s;
                            flag_v_r <= 1'b0;
                            flag_n_r <= lo_nxt_s[WIDTH-1];
                            flag_z_r <= ~(|lo_nxt_s);
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_r <= S_IDLE;
                    end
                end
                default: state_r <= S_IDLE;
            endcase
        end
    end

    // in_ready is gated by rst_n so it reads 0 for the whole time reset is applied.
    assign in_ready  = rst_n & (state_r == S_IDLE);
    assign out_valid = (state_r == S_DONE);
    assign result    = result_r;
    assign carry     = carry_r;
    assign overflow  = overflow_r;
    assign negative  = negative_r;
    assign zero      = zero_r;
    assign illegal   = illegal_r;
    assign flag_c    = flag_c_r;
    assign flag_v    = flag_v_r;
    assign flag_n    = flag_n_r;
    assign flag_z    = flag_z_r;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=16): table of directed vectors with
// hand-computed results, plus hand-written stall and mid-operation reset sequences.

module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [15:0] operand1;
    logic [15:0] operand2;
    logic        set_flags;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        carry, overflow, negative, zero, illegal;
    logic        flag_c, flag_v, flag_n, flag_z;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .operand1(operand1), .operand2(operand2), .set_flags(set_flags),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry(carry), .overflow(overflow),
        .negative(negative), .zero(zero), .illegal(illegal),
        .flag_c(flag_c), .flag_v(flag_v), .flag_n(flag_n), .flag_z(flag_z)
    );

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        sf;
        logic [15:0] res;
        logic        c;
        logic        v;
        logic        n;
        logic        z;
        logic        ill;
        int          lat;
    } vec_t;

    vec_t       tbl[$];
    int         total = 0;
    int         bad   = 0;
    logic [3:0] exp_f = 4'b0000;  // expected {C,V,N,Z} flag register

    function automatic vec_t mk(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                                input logic sf, input logic [15:0] r, input logic c,
                                input logic v, input logic n, input logic z,
                                input logic ill, input int lat);
        vec_t t;
        t.op = o; t.a = a; t.b = b; t.sf = sf; t.res = r;
        t.c = c; t.v = v; t.n = n; t.z = z; t.ill = ill; t.lat = lat;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_op(input vec_t v, input string tag);
        int lat;
        @(negedge clk);
        op = v.op; operand1 = v.a; operand2 = v.b; set_flags = v.sf; in_valid = 1'b1;
        #1;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(v.lat));
        chk({tag, "_result"}, 32'(result), 32'(v.res));
        chk({tag, "_cvnz"}, 32'({carry, overflow, negative, zero}), 32'({v.c, v.v, v.n, v.z}));
        chk({tag, "_illegal"}, 32'(illegal), 32'(v.ill));
        chk({tag, "_busy_ready"}, 32'(in_ready), 32'd0);
        if (v.sf && !v.ill) exp_f = {v.c, v.v, v.n, v.z};
        chk({tag, "_flagreg"}, 32'({flag_c, flag_v, flag_n, flag_z}), 32'(exp_f));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int lat;
        rst_n = 1'b0; in_valid = 1'b0; op = 4'h0; operand1 = 16'h0000;
        operand2 = 16'h0000; set_flags = 1'b0; out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_flags", 32'({carry, overflow, negative, zero, illegal}), 32'd0);
        chk("rst_flagreg", 32'({flag_c, flag_v, flag_n, flag_z}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // out_ready with nothing pending has no effect
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("idle_out_ready", 32'(out_valid), 32'd0);

        //               op     a         b         sf    res       c     v     n     z     ill   lat
        tbl.push_back(mk(4'h0, 16'h7FFF, 16'h0001, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1));
        tbl.push_back(mk(4'h1, 16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1));
        tbl.push_back(mk(4'h7, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1));
        tbl.push_back(mk(4'h2, 16'hF0F0, 16'h0FF0, 1'b0, 16'h00F0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1));
        tbl.push_back(mk(4'h3, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1));
        tbl.push_back(mk(4'h4, 16'hAAAA, 16'hFFFF, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1));
        tbl.push_back(mk(4'h5, 16'h1234, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1));
        tbl.push_back(mk(4'h6, 16'h1234, 16'h8000, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1));
        tbl.push_back(mk(4'h8, 16'h8001, 16'h0011, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1));
        tbl.push_back(mk(4'hA, 16'h8000, 16'h000F, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1));
        tbl.push_back(mk(4'h9, 16'h1234, 16'h0000, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1));
        tbl.push_back(mk(4'h9, 16'h0003, 16'h0001, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1));
        tbl.push_back(mk(4'h8, 16'h4000, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1));
        tbl.push_back(mk(4'hB, 16'h0003, 16'h0005, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 17));
        tbl.push_back(mk(4'hB, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 17));
        tbl.push_back(mk(4'hD, 16'h1234, 16'h5678, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1));
`ifdef ALU_SEQ_DIVIDER_EN
        tbl.push_back(mk(4'hC, 16'd100,  16'd7,    1'b0, 16'd14,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 17));
        tbl.push_back(mk(4'hC, 16'h0005, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1));
`else
        tbl.push_back(mk(4'hC, 16'd100,  16'd7,    1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1));
`endif
        tbl.push_back(mk(4'h1, 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1));
        tbl.push_back(mk(4'h7, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1));
        tbl.push_back(mk(4'h0, 16'h8000, 16'h8000, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1));
        tbl.push_back(mk(4'h7, 16'h0001, 16'h0001, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1));

        foreach (tbl[i]) do_op(tbl[i], $sformatf("v%0d", i));

        // MUL with a held in_valid during BUSY (must be ignored) and a 5-cycle output stall
        @(negedge clk);
        op = 4'hB; operand1 = 16'h0100; operand2 = 16'h0101; set_flags = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        op = 4'h0; operand1 = 16'h1111; operand2 = 16'h2222; set_flags = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            chk("stall_busy_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            lat++;
        end
        chk("stall_latency", 32'(lat), 32'd17);
        chk("stall_result", 32'(result), 32'h0100);
        chk("stall_carry", 32'(carry), 32'd1);
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("stall_hold_valid", 32'(out_valid), 32'd1);
            chk("stall_hold_result", 32'(result), 32'h0100);
            chk("stall_hold_cvnz", 32'({carry, overflow, negative, zero}), 32'h8);
            chk("stall_hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        exp_f = 4'b1000;
        chk("stall_flagreg", 32'({flag_c, flag_v, flag_n, flag_z}), 32'(exp_f));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("stall_drop", 32'(out_valid), 32'd0);

        // Reset in the middle of a MUL abandons it and clears the flag register
        @(negedge clk);
        op = 4'hB; operand1 = 16'h0003; operand2 = 16'h0005; set_flags = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_flagreg", 32'({flag_c, flag_v, flag_n, flag_z}), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_result", 32'(result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_f = 4'b0000;
        repeat (20) begin
            @(posedge clk);
            #1;
            chk("midrst_no_output", 32'(out_valid), 32'd0);
        end
        do_op(mk(4'h0, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1), "post_rst_add");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked, multi-cycle successor to the 16-bit combinational ALU of the single-cycle datapath.
- Accepts one operation per transaction on a valid/ready input channel and returns result plus C/V/N/Z on a valid/ready output channel.
- Adds shifts, add-with-carry, an iterative shift-add multiplier and an architectural flag register (NZCV) for the multi-cycle core.

Parameters:
- WIDTH, 16: operand/result width; must be ≥4 and a power of two.
- SHW, $clog2(WIDTH): shift-amount width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  operation presented.
- in_ready  output  1  block can accept an operation.
- op  input  4  opcode (see Behaviour).
- operand1  input  WIDTH  first operand.
- operand2  input  WIDTH  second operand / shift amount.
- set_flags  input  1  update architectural flag register on completion.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- result  output  WIDTH  operation result.
- carry, overflow, negative, zero  output  1 each  result flags of this operation.
- illegal  output  1  opcode was unsupported.
- flag_c, flag_v, flag_n, flag_z  output  1 each  architectural flag register.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; in_ready=0 during reset, 1 the cycle after; out_valid=0; result=0; all result flags, illegal and flag_* =0; iteration counter=0. Reset mid-MUL or mid-DONE abandons the operation with no output.
- FSM:
  - IDLE: in_ready=1. On in_valid, latch op, operands and set_flags. Single-cycle ops compute and register result -> DONE; MUL -> BUSY.
  - BUSY: in_ready=0; one shift-add step per cycle for WIDTH cycles; then -> DONE.
  - DONE: out_valid=1 and outputs held stable; in_ready=0. On out_ready -> IDLE, and out_valid drops the next cycle.
- Latency (accept edge to out_valid high): single-cycle ops 1 cycle; MUL WIDTH+1 cycles. Throughput is at most one op per 2 cycles; no skid buffer.
- Opcodes:
  - 0000 ADD, 0001 SUB (op1+~op2+1). Carry = bit WIDTH of the WIDTH+1-bit sum. Overflow per two's-complement sign rule.
  - 0010 AND, 0011 OR, 0100 XOR, 0101 NOT (~op2), 0110 PASS (op2). C=V=N=0; Z computed.
  - 0111 ADC: op1+op2+flag_c, using the flag register value sampled at accept. Flags as ADD.
  - 1000 SHL, 1001 SHR, 1010 ASR: amount = operand2[SHW-1:0]; upper bits ignored. C = last bit shifted out; C=0 when amount=0. V=0. N = result MSB.
  - 1011 MUL: unsigned, result = low WIDTH bits of the product. C=1 if the high half is nonzero. V=0. N = result MSB.
  - 1100 DIVU: see Optional Feature.
  - Others: result=0, all flags 0, illegal=1; completes in 1 cycle.
- Zero=1 iff result==0 for every legal op. Negative=result[WIDTH-1] for ADD/SUB/ADC/shifts/MUL.
- Flag register: loaded from {carry,overflow,negative,zero} on the clock edge entering DONE, only if the latched set_flags=1 and illegal=0. It is otherwise unchanged, including across back-to-back ops.
- in_valid while in_ready=0 is ignored; the source must hold it. out_ready while out_valid=0 has no effect.

Optional Feature:
- Macro ALU_SEQ_DIVIDER_EN.
- Defined: op 1100 DIVU is legal. Restoring unsigned division, one quotient bit per cycle in BUSY, latency WIDTH+1. result = quotient; C = (remainder≠0); V=0; N = result MSB.
  - Divide by zero: result = all ones, V=1, C=0, latency 1.
- Undefined: 1100 is illegal (result 0, illegal=1); no divider logic is synthesised.

Test Plan:
- WIDTH=16. ADD 0x7FFF+0x0001, set_flags=1 -> result 0x8000, V=1, N=1, C=0, Z=0; out_valid 1 cycle after accept; flag_v=1.
- SUB 0x0005-0x0005, then ADC 0xFFFF+0x0000 -> SUB gives 0x0000, Z=1, C=1; ADC uses flag_c=1 and gives 0x0000, C=1, Z=1.
- MUL 0x0100×0x0101 with out_ready low for 5 cycles after out_valid -> result 0x0100, C=1; out_valid exactly 17 cycles after accept; outputs stable while stalled; in_ready=0 throughout.
- SHL 0x8001 by operand2=0x0011 (amount 1) -> 0x0002, C=1. ASR 0x8000 by 15 -> 0xFFFF, N=1. SHR by 0 -> unchanged, C=0.
- Opcode 1101 -> illegal=1, result 0, flag register unchanged. With ALU_SEQ_DIVIDER_EN: DIVU 100/7 -> 14, C=1; DIVU x/0 -> 0xFFFF, V=1.
- Assert rst_n=0 mid-MUL (cycle 8) -> next cycle out_valid=0 and flag_* =0; a new ADD issued after reset completes normally.
